// File: rtl/filter_ctrl_pkg.sv
// Shared types for the filter-phase controller: phase FSM states and per-slot states.
package filter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fctrl_state_t;

    typedef enum logic [1:0] {
        FREE,
        FILTERING,
        READY,
        SENDING
    } slot_state_t;

endpackage

// File: rtl/pipelined_filter_ctrl_slots.sv
// Round-robin slot tracker: per-slot state plus write (read-issue) and read (send) pointers.
// Ports:
//   alloc        - accepted read_done: slot wr_ptr -> FILTERING, wr_ptr advances
//   filter_done  - per-slot: FILTERING -> READY (ignored for other states)
//   send_start   - head slot (head_idx) -> SENDING
//   send_done    - accepted send_done: SENDING head slot -> FREE, rd_ptr advances
//   clear        - all slots FREE, both pointers 0 (overrides everything)
//   wr_free      - lookahead: slot at next wr_ptr is FREE after this cycle's events
//   head_ready   - lookahead: slot at next rd_ptr is READY after this cycle's events
//   head_idx     - lookahead rd_ptr (slot that head_ready refers to)
//   wr_idx       - current wr_ptr (slot that alloc fills this cycle)
module rr_slot_tracker
    import filter_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = 2,
    parameter int unsigned SEL_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   alloc,
    input  logic [NUM_FILTERS-1:0] filter_done,
    input  logic                   send_start,
    input  logic                   send_done,
    input  logic                   clear,
    output logic                   wr_free,
    output logic                   head_ready,
    output logic [SEL_W-1:0]       head_idx,
    output logic [SEL_W-1:0]       wr_idx
);

    slot_state_t      slot_q [NUM_FILTERS];
    slot_state_t      slot_d [NUM_FILTERS];
    slot_state_t      base_c [NUM_FILTERS];
    logic [SEL_W-1:0] wr_q, wr_d, wr_n;
    logic [SEL_W-1:0] rd_q, rd_d, rd_n;

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
        return (p == SEL_W'(NUM_FILTERS - 1)) ? '0 : p + SEL_W'(1);
    endfunction

    // Slot states and pointers after this cycle's input events, before any new send.
    always_comb begin
        base_c = slot_q;
        wr_n   = wr_q;
        rd_n   = rd_q;
        for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
            if (filter_done[i] && (slot_q[i] == FILTERING)) begin
                base_c[i] = READY;
            end
        end
        if (send_done) begin
            base_c[rd_q] = FREE;
            rd_n         = next_ptr(rd_q);
        end
        if (alloc) begin
            base_c[wr_q] = FILTERING;
            wr_n         = next_ptr(wr_q);
        end
    end

    assign wr_free    = (base_c[wr_n] == FREE);
    assign head_ready = (base_c[rd_n] == READY);
    assign head_idx   = rd_n;
    assign wr_idx     = wr_q;

    // Apply the send decision and clear on top of the event-updated state.
    always_comb begin
        slot_d = base_c;
        wr_d   = wr_n;
        rd_d   = rd_n;
        if (send_start) begin
            slot_d[rd_n] = SENDING;
        end
        if (clear) begin
            for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
                slot_d[i] = FREE;
            end
            wr_d = '0;
            rd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
                slot_q[i] <= FREE;
            end
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            slot_q <= slot_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

endmodule

// File: rtl/pipelined_filter_ctrl.sv
// Filter-phase controller: overlaps block reads, filtering on NUM_FILTERS units and
// in-order transmission of results, counting NUM_BLOCKS blocks per phase.
// Ports:
//   clk, n_rst   - clock (rising edge), async active-low reset
//   start        - pulse: begin a phase (ignored unless idle)
//   abort        - level: cancel phase, everything back to idle
//   read_done    - pulse: requested block has been read
//   filter_done  - per-unit pulse: that unit finished filtering
//   send_done    - pulse: transmitter finished the current result
//   en_read      - pulse: read next block
//   en_filter    - one-hot pulse: start filter unit on the block just read
//   en_send      - pulse: send result of slot send_sel
//   send_sel     - slot being sent, held until the next send
//   busy         - high while a phase is in progress
//   phase_done   - pulse: all blocks sent
//   blk_sent     - results sent in the current phase
module pipelined_filter_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = 2,
    parameter int unsigned NUM_BLOCKS  = 16,
    parameter int unsigned CNT_W       = $clog2(NUM_BLOCKS + 1),
    parameter int unsigned SEL_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   read_done,
    input  logic [NUM_FILTERS-1:0] filter_done,
    input  logic                   send_done,
    output logic                   en_read,
    output logic [NUM_FILTERS-1:0] en_filter,
    output logic                   en_send,
    output logic [SEL_W-1:0]       send_sel,
    output logic                   busy,
    output logic                   phase_done,
    output logic [CNT_W-1:0]       blk_sent
);

    fctrl_state_t state_q, state_d;

    logic                   en_read_q,    en_read_d;
    logic [NUM_FILTERS-1:0] en_filter_q,  en_filter_d;
    logic                   en_send_q,    en_send_d;
    logic [SEL_W-1:0]       send_sel_q,   send_sel_d;
    logic                   busy_q,       busy_d;
    logic                   phase_done_q, phase_done_d;
    logic [CNT_W-1:0]       blk_sent_q,   blk_sent_d;
    logic [CNT_W-1:0]       rd_cnt_q,     rd_cnt_d;
    logic                   rd_out_q,     rd_out_d;
    logic                   sending_q,    sending_d;

    logic                   alloc_c;
    logic                   send_done_c;
    logic                   send_start_c;
    logic                   last_send_c;
    logic                   clear_c;
    logic                   wr_free;
    logic                   head_ready;
    logic [SEL_W-1:0]       head_idx;
    logic [SEL_W-1:0]       wr_idx;

    // Accepted events: spurious read_done/send_done pulses are dropped here.
    assign alloc_c      = (state_q == RUN) && read_done && rd_out_q;
    assign send_done_c  = (state_q == RUN) && send_done && sending_q;
    assign send_start_c = (state_q == RUN) && !abort && head_ready;
    assign last_send_c  = send_done_c && (blk_sent_q == CNT_W'(NUM_BLOCKS - 1));
    // Slots are re-initialised on abort and at the end of every phase.
    assign clear_c      = abort || (state_q == DONE);

    rr_slot_tracker #(
        .NUM_FILTERS (NUM_FILTERS),
        .SEL_W       (SEL_W)
    ) u_slots (
        .clk         (clk),
        .n_rst       (n_rst),
        .alloc       (alloc_c),
        .filter_done (filter_done),
        .send_start  (send_start_c),
        .send_done   (send_done_c),
        .clear       (clear_c),
        .wr_free     (wr_free),
        .head_ready  (head_ready),
        .head_idx    (head_idx),
        .wr_idx      (wr_idx)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (last_send_c) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Pulse and counter decisions; everything appears on the outputs next cycle.
    always_comb begin
        en_read_d    = 1'b0;
        en_filter_d  = '0;
        en_send_d    = 1'b0;
        send_sel_d   = send_sel_q;
        busy_d       = busy_q;
        phase_done_d = 1'b0;
        blk_sent_d   = blk_sent_q;
        rd_cnt_d     = rd_cnt_q;
        rd_out_d     = rd_out_q;
        sending_d    = sending_q;
        if (abort) begin
            send_sel_d = '0;
            busy_d     = 1'b0;
            blk_sent_d = '0;
            rd_cnt_d   = '0;
            rd_out_d   = 1'b0;
            sending_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_d     = 1'b1;
                        en_read_d  = 1'b1;
                        rd_out_d   = 1'b1;
                        rd_cnt_d   = CNT_W'(1);
                        blk_sent_d = '0;
                        send_sel_d = '0;
                        sending_d  = 1'b0;
                    end
                end
                RUN: begin
                    if (alloc_c) begin
                        en_filter_d = NUM_FILTERS'(1) << wr_idx;
                        rd_out_d    = 1'b0;
                    end
                    // A read completing this cycle no longer blocks the next one.
                    if ((!rd_out_q || alloc_c) && (rd_cnt_q < CNT_W'(NUM_BLOCKS)) && wr_free) begin
                        en_read_d = 1'b1;
                        rd_out_d  = 1'b1;
                        rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                    end
                    if (send_done_c) begin
                        sending_d = 1'b0;
                        if (blk_sent_q != CNT_W'(NUM_BLOCKS)) begin
                            blk_sent_d = blk_sent_q + CNT_W'(1);
                        end
                    end
                    if (last_send_c) begin
                        busy_d       = 1'b0;
                        phase_done_d = 1'b1;
                    end
                    if (send_start_c) begin
                        en_send_d  = 1'b1;
                        send_sel_d = head_idx;
                        sending_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            en_read_q    <= 1'b0;
            en_filter_q  <= '0;
            en_send_q    <= 1'b0;
            send_sel_q   <= '0;
            busy_q       <= 1'b0;
            phase_done_q <= 1'b0;
            blk_sent_q   <= '0;
            rd_cnt_q     <= '0;
            rd_out_q     <= 1'b0;
            sending_q    <= 1'b0;
        end else begin
            en_read_q    <= en_read_d;
            en_filter_q  <= en_filter_d;
            en_send_q    <= en_send_d;
            send_sel_q   <= send_sel_d;
            busy_q       <= busy_d;
            phase_done_q <= phase_done_d;
            blk_sent_q   <= blk_sent_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_out_q     <= rd_out_d;
            sending_q    <= sending_d;
        end
    end

    assign en_read    = en_read_q;
    assign en_filter  = en_filter_q;
    assign en_send    = en_send_q;
    assign send_sel   = send_sel_q;
    assign busy       = busy_q;
    assign phase_done = phase_done_q;
    assign blk_sent   = blk_sent_q;

endmodule
